int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL provide: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: irq_in  in  8  peripheral interrupt requests, asynchronous to clock.
REQ-004 SHALL provide: bus_sel  in  1  register access strobe, single-cycle.
REQ-005 SHALL provide: bus_we  in  1  1 = write, 0 = read (qualified by bus_sel).
REQ-006 SHALL provide: bus_addr  in  3  register word select.
REQ-007 SHALL provide: bus_wdata  in  32  write data.
REQ-008 SHALL provide: bus_rdata  out  32  read data.
REQ-009 SHALL provide: Int  out  5  hardware interrupt lines to CP0 Int[4:0].

Function
REQ-010 SHALL implement this register map: 0 PENDING (R, write-1-to-clear; bit 8 = timer), 1 MASK (RW, bits 7:0), 2 MODE (RW, bits 7:0; 1 = edge, 0 = level), 3 reserved, 4 COUNT (RW), 5 COMPARE (RW), 6-7 reserved.
REQ-011 SHALL pass each irq_in bit through a two-flop synchronizer before any use.
REQ-012 SHALL, in edge mode, set PENDING[i] on the cycle after a 0->1 transition of synchronized irq_in[i].
REQ-013 SHALL, in level mode, load PENDING[i] from synchronized irq_in[i] every cycle; W1C has no lasting effect.
REQ-014 SHALL give set priority over clear when an edge set and a W1C clear hit the same bit in the same cycle.
REQ-015 SHALL register Int[k] = |(PENDING[2k+1:2k] & MASK[2k+1:2k]) for k = 0..3.
REQ-016 SHALL meet this latency: irq_in high at edge N (edge mode, masked in) -> PENDING set after edge N+2 -> Int high after edge N+3.
REQ-017 SHALL drive bus_rdata combinationally with the addressed register when bus_sel=1 and bus_we=0, else 0.
REQ-018 SHALL return 0 on reads of reserved addresses, zero-extend 8-bit registers, and ignore writes to reserved addresses and read-only bits.
REQ-019 SHALL apply mode changes from the next cycle, with no spurious edge generated by the change itself.

Reset
REQ-020 SHALL, on reset assertion, asynchronously clear PENDING, MASK, MODE (all level), synchronizers, edge history, COUNT and Int.
REQ-021 SHALL set COMPARE to 0xFFFFFFFF and bus_rdata to 0 on reset.
REQ-022 SHALL discard any in-flight edge on reset, with no interrupt after release unless a new edge arrives.

Configuration
REQ-023 SHALL gate the timer with macro INT_CTRL_TIMER_EN.
REQ-024 SHALL, with INT_CTRL_TIMER_EN defined, implement these timer rules:
- COUNT increments every cycle and wraps 0xFFFFFFFF->0.
- COUNT == COMPARE sets PENDING[8] on the next edge.
- Int[4] = registered PENDING[8], unmasked.
- A write to COMPARE clears PENDING[8]; W1C of bit 8 also clears it.
- A COUNT write takes priority over the increment.
REQ-025 SHALL, without INT_CTRL_TIMER_EN, tie these off:
- No COUNT/COMPARE storage.
- Addresses 4-5 read 0; writes are ignored.
- PENDING[8] reads 0; Int[4] tied 0.

Structure
REQ-026 SHALL place these in shared package int_ctrl_pkg:
- NUM_SRC = 8.
- Register address constants.
- Reset value of COMPARE.
REQ-027 SHALL implement synchronizer plus edge detect as sub-module irq_sync, instantiated once per source.

Verification
REQ-028 SHALL cover: MODE=0x01, MASK=0x01, irq_in[0] 0->1 at edge N -> PENDING=0x001 after N+2, Int=5'b00001 after N+3; W1C 0x1 -> Int=0 two edges later.
REQ-029 SHALL cover: level mode, MASK=0x80, irq_in[7] held high, W1C 0x80 -> PENDING[7] still 1 next cycle; irq_in[7] low -> Int[3]=0 within 4 cycles.
REQ-030 SHALL cover: edge set and W1C to the same bit in the same cycle -> PENDING bit remains 1.
REQ-031 SHALL cover (macro on): COUNT=0x10, COMPARE=0x14 -> Int[4]=1 two cycles after COUNT reaches 0x14; COMPARE write -> Int[4]=0.
REQ-032 SHALL cover (macro off): read addr 5 -> 0x00000000; Int[4] constantly 0.
REQ-033 SHALL cover: reset asserted mid-cycle with PENDING=0xFF -> all outputs 0 immediately; COMPARE reads 0xFFFFFFFF after release (macro on).

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the int_ctrl interrupt controller: source count,
// register word addresses, COMPARE reset value and the Int line folding.
package int_ctrl_pkg;

  localparam int NUM_SRC = 8;
  localparam int NUM_INT = 5;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;
  localparam logic [2:0] ADDR_COMPARE = 3'd5;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Pairs of masked sources share one CPU line; bit 8 (timer) drives line 4 unmasked.
  function automatic logic [NUM_INT-1:0] int_lines(input logic [8:0] pend,
                                                   input logic [7:0] mask);
    logic [NUM_INT-1:0] lines;
    for (int k = 0; k < 4; k++) begin
      lines[k] = |(pend[2*k +: 2] & mask[2*k +: 2]);
    end
    lines[4] = pend[8];
    return lines;
  endfunction

endpackage

// File: rtl/int_ctrl_sync.sv
// irq_sync: two-flop synchronizer for one asynchronous request plus a
// rising-edge detector on the synchronized value. The edge history always
// runs, independent of the source mode, so mode changes never fake an edge.
module irq_sync (
  input  logic clock,
  input  logic reset,
  input  logic irq_async,
  output logic level,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;

  // Next-state: shift the request through the synchronizer and history.
  always_comb begin
    s1_d   = irq_async;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: 8-source interrupt controller with PENDING/MASK/MODE registers
// and registered CPU lines Int[4:0]. Optional COUNT/COMPARE timer on
// PENDING[8]/Int[4] is built only when macro INT_CTRL_TIMER_EN is defined.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   irq_in,
  input  logic                 bus_sel,
  input  logic                 bus_we,
  input  logic [2:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic [NUM_INT-1:0]   Int
);

  logic [NUM_SRC-1:0] sync_lvl;
  logic [NUM_SRC-1:0] sync_rise;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    irq_sync u_sync (
      .clock     (clock),
      .reset     (reset),
      .irq_async (irq_in[i]),
      .level     (sync_lvl[i]),
      .rise      (sync_rise[i])
    );
  end

  logic               wr;
  logic               rd;
  logic [8:0]         w1c;
  logic [8:0]         pending_q, pending_d;
  logic [7:0]         mask_q, mask_d;
  logic [7:0]         mode_q, mode_d;
  logic [NUM_INT-1:0] int_q, int_d;
  logic [31:0]        rdata;

  assign wr  = bus_sel & bus_we;
  assign rd  = bus_sel & ~bus_we;
  assign w1c = (wr && bus_addr == ADDR_PENDING) ? bus_wdata[8:0] : 9'd0;

`ifdef INT_CTRL_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        compare_wr;

  assign compare_wr = wr && bus_addr == ADDR_COMPARE;
`else
  logic unused_ok;
  assign unused_ok = ^{bus_wdata[31:9], w1c[8]};
`endif

  // Next-state for pending/mask/mode/Int (and timer); edge set beats W1C clear.
  always_comb begin
    pending_d = pending_q;
    mask_d    = (wr && bus_addr == ADDR_MASK) ? bus_wdata[7:0] : mask_q;
    mode_d    = (wr && bus_addr == ADDR_MODE) ? bus_wdata[7:0] : mode_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) pending_d[i] = (pending_q[i] & ~w1c[i]) | sync_rise[i];
      else           pending_d[i] = sync_lvl[i];
    end
`ifdef INT_CTRL_TIMER_EN
    count_d      = (wr && bus_addr == ADDR_COUNT) ? bus_wdata : count_q + 32'd1;
    compare_d    = compare_wr ? bus_wdata : compare_q;
    pending_d[8] = (pending_q[8] & ~w1c[8] & ~compare_wr) | (count_q == compare_q);
`else
    pending_d[8] = 1'b0;
`endif
    int_d = int_lines(pending_q, mask_q);
  end

  // Register file and Int lines; everything clears asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      int_q     <= '0;
`ifdef INT_CTRL_TIMER_EN
      count_q   <= '0;
      compare_q <= COMPARE_RST;
`endif
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
`ifdef INT_CTRL_TIMER_EN
      count_q   <= count_d;
      compare_q <= compare_d;
`endif
    end
  end

  // Combinational read mux; zero when idle, writing, in reset or reserved.
  always_comb begin
    rdata = 32'd0;
    if (rd && !reset) begin
      case (bus_addr)
        ADDR_PENDING: rdata = {23'd0, pending_q};
        ADDR_MASK:    rdata = {24'd0, mask_q};
        ADDR_MODE:    rdata = {24'd0, mode_q};
`ifdef INT_CTRL_TIMER_EN
        ADDR_COUNT:   rdata = count_q;
        ADDR_COMPARE: rdata = compare_q;
`endif
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign bus_rdata = rdata;
  assign Int       = int_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-indexed behavioural model.
module tb_int_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [4:0]  int_o;

  int n_cmp = 0;
  int n_bad = 0;

  int_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .irq_in    (irq_in),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .Int       (int_o)
  );

  always #5 clock = ~clock;

  // Model: register contents plus the irq_in values sampled at the last three edges.
  logic [8:0]  m_pend;
  logic [7:0]  m_mask, m_mode;
  logic [4:0]  m_int;
  logic [31:0] m_count, m_cmp;
  logic [7:0]  smp1, smp2, smp3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_int = '0;
    m_count = '0; m_cmp = 32'hFFFF_FFFF;
    smp1 = '0; smp2 = '0; smp3 = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {23'd0, m_pend};
      3'd1: return {24'd0, m_mask};
      3'd2: return {24'd0, m_mode};
`ifdef INT_CTRL_TIMER_EN
      3'd4: return m_count;
      3'd5: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the specified behaviour, using the inputs present now.
  // A source set at edge t reflects irq_in as sampled at edge t-2.
  task automatic model_edge();
    logic [8:0] w1c, np;
    logic [4:0] ni;
    logic       wr;
    wr  = bus_sel & bus_we;
    w1c = (wr && bus_addr == 3'd0) ? bus_wdata[8:0] : 9'd0;
    for (int k = 0; k < 4; k++) ni[k] = |(m_pend[2*k +: 2] & m_mask[2*k +: 2]);
    ni[4] = m_pend[8];
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i]) np[i] = (m_pend[i] & ~w1c[i]) | (smp2[i] & ~smp3[i]);
      else           np[i] = smp2[i];
    end
`ifdef INT_CTRL_TIMER_EN
    np[8] = (m_pend[8] && !w1c[8] && !(wr && bus_addr == 3'd5)) || (m_count == m_cmp);
    m_count = (wr && bus_addr == 3'd4) ? bus_wdata : m_count + 32'd1;
    if (wr && bus_addr == 3'd5) m_cmp = bus_wdata;
`else
    np[8] = 1'b0;
`endif
    if (wr && bus_addr == 3'd1) m_mask = bus_wdata[7:0];
    if (wr && bus_addr == 3'd2) m_mode = bus_wdata[7:0];
    m_pend = np;
    m_int  = ni;
    smp3 = smp2; smp2 = smp1; smp1 = irq_in;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
    check("int_lines", {27'd0, int_o}, {27'd0, m_int});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
  endtask

  task automatic rd_chk(input logic [2:0] a, input string tag, output logic [31:0] v);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1;
    v = bus_rdata;
    check(tag, v, model_read(a));
    bus_sel = 1'b0;
  endtask

  // Reset pulse entirely between two clock edges, with a PENDING read active.
  task automatic pulse_reset();
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 3'd0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_int_async", {27'd0, int_o}, 32'd0);
    check("rst_rdata_async", bus_rdata, 32'd0);
    model_reset();
    bus_sel = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; irq_in = '0; bus_sel = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    model_reset();

    // Reset state
    #3;
    check("reset_int", {27'd0, int_o}, 32'd0);
    bus_sel = 1'b1; bus_addr = 3'd0;
    #1;
    check("reset_rdata", bus_rdata, 32'd0);
    bus_sel = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    rd_chk(3'd0, "rst_pending", v);
    rd_chk(3'd1, "rst_mask", v);
    rd_chk(3'd2, "rst_mode", v);
`ifdef INT_CTRL_TIMER_EN
    rd_chk(3'd5, "rst_compare", v);
    check("rst_compare_const", v, 32'hFFFF_FFFF);
`endif

    // Edge mode source 0: PENDING after N+2, Int after N+3, W1C drops Int
    wr_reg(3'd2, 32'h01);
    wr_reg(3'd1, 32'h01);
    irq_in = 8'h01;
    tick(); tick(); tick();
    rd_chk(3'd0, "edge_pend_model", v);
    check("edge_pend_const", v, 32'h001);
    tick();
    check("edge_int_const", {27'd0, int_o}, 32'h01);
    wr_reg(3'd0, 32'h1);
    tick();
    check("w1c_int_const", {27'd0, int_o}, 32'h00);

    // Level mode source 7: W1C has no lasting effect, low input drops Int[3]
    wr_reg(3'd2, 32'h00);
    irq_in = 8'h80;
    wr_reg(3'd1, 32'h80);
    tick(); tick(); tick();
    wr_reg(3'd0, 32'h80);
    rd_chk(3'd0, "level_pend_model", v);
    check("level_pend7_const", {31'd0, v[7]}, 32'd1);
    irq_in = 8'h00;
    tick(); tick(); tick(); tick();
    check("level_int3_low", {31'd0, int_o[3]}, 32'd0);

    // Edge set and W1C of the same bit in the same cycle: set wins
    wr_reg(3'd2, 32'h02);
    tick(); tick(); tick();
    irq_in = 8'h02;
    tick(); tick();
    wr_reg(3'd0, 32'h02);
    rd_chk(3'd0, "set_vs_clr_model", v);
    check("set_vs_clr_const", {31'd0, v[1]}, 32'd1);

`ifdef INT_CTRL_TIMER_EN
    // Timer compare match and clear by COMPARE write
    irq_in = 8'h00;
    wr_reg(3'd4, 32'h10);
    wr_reg(3'd5, 32'h14);
    for (int i = 0; i < 16 && m_count != 32'h14; i++) tick();
    rd_chk(3'd4, "timer_count", v);
    tick(); tick();
    check("timer_int4_set", {31'd0, int_o[4]}, 32'd1);
    wr_reg(3'd5, 32'hFFFF_FFFF);
    tick();
    check("timer_int4_clr", {31'd0, int_o[4]}, 32'd0);
`else
    // Timer absent: COUNT/COMPARE read zero and ignore writes, Int[4] stays low
    rd_chk(3'd5, "notimer_cmp_model", v);
    check("notimer_cmp_const", v, 32'd0);
    wr_reg(3'd5, 32'h14);
    wr_reg(3'd4, 32'h13);
    rd_chk(3'd5, "notimer_cmp_wr", v);
    rd_chk(3'd4, "notimer_cnt_wr", v);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("notimer_int4", {31'd0, int_o[4]}, 32'd0);
    end
`endif

    // Reset mid-cycle with PENDING = 0xFF
    wr_reg(3'd2, 32'h00);
    wr_reg(3'd1, 32'hFF);
    irq_in = 8'hFF;
    tick(); tick(); tick(); tick();
    rd_chk(3'd0, "pend_ff_model", v);
    check("pend_ff_const", {24'd0, v[7:0]}, 32'hFF);
    irq_in = 8'h00;
    pulse_reset();
`ifdef INT_CTRL_TIMER_EN
    rd_chk(3'd5, "post_rst_compare", v);
    check("post_rst_compare_const", v, 32'hFFFF_FFFF);
`endif
    rd_chk(3'd1, "post_rst_mask", v);

    // In-flight edge discarded by reset
    wr_reg(3'd2, 32'h04);
    wr_reg(3'd1, 32'h04);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    pulse_reset();
    for (int i = 0; i < 5; i++) tick();
    rd_chk(3'd0, "inflight_pend", v);
    check("inflight_pend_const", v, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus_sel = 1'b1; bus_we = 1'b1;
        bus_addr = 3'($urandom_range(0, 7));
        bus_wdata = $urandom;
      end
      tick();
      rd_chk(3'($urandom_range(0, 7)), "rand_read", v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
